logic_basic_queue_generic_write: RTL and testbench

Write-side controller of the generic RAM-based queue. It accepts an AXI4-Stream-style input (rx_tvalid/rx_tready/rx_tdata) and drives the RAM write port (write_enable, write_pointer, write_data). It also owns the fill counter `capacity`, which is consumed by the queue read-side controller. The read side returns its `read_enable` so the counter can be decremented.

---
 rtl/logic_basic_queue_generic_write.sv | 49 ++++
 tb/tb_logic_basic_queue_generic_write.sv | 95 +++++++++
 2 files changed

// File: rtl/logic_basic_queue_generic_write.sv
// logic_basic_queue_generic_write: write-side controller of a RAM queue; registers
// stream input into RAM writes and owns the committed-word fill counter.
module logic_basic_queue_generic_write #(
  parameter int DATA_WIDTH    = 1,
  parameter int ADDRESS_WIDTH = 1,
  parameter int ALMOST_FULL   = 1
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     rx_tvalid,
  output logic                     rx_tready,
  input  logic [DATA_WIDTH-1:0]    rx_tdata,
  output logic                     write_enable,
  output logic [ADDRESS_WIDTH-1:0] write_pointer,
  output logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     read_enable,
  output logic [ADDRESS_WIDTH:0]   capacity,
  output logic                     almost_full
);
  localparam int CW = ADDRESS_WIDTH + 2;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDRESS_WIDTH);
  localparam logic [CW-1:0] THRESHOLD = DEPTH - CW'(ALMOST_FULL);
  logic          accepted;
  logic [CW-1:0] cap_sum, cap_next, used_next;
  // one spare bit keeps the intermediate sums clear of wrap; read on empty saturates at 0
  always_comb begin
    accepted  = rx_tvalid && rx_tready;
    cap_sum   = {1'b0, capacity} + CW'(write_enable);
    cap_next  = (read_enable && cap_sum != '0) ? cap_sum - CW'(1) : cap_sum;
    used_next = cap_next + CW'(accepted);
  end
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rx_tready     <= 1'b0;
      write_enable  <= 1'b0;
      write_pointer <= '0;
      write_data    <= '0;
      capacity      <= '0;
      almost_full   <= 1'b0;
    end else begin
      rx_tready     <= used_next < DEPTH;
      write_enable  <= accepted;
      write_pointer <= write_pointer + ADDRESS_WIDTH'(write_enable);
      write_data    <= accepted ? rx_tdata : write_data;
      capacity      <= cap_next[ADDRESS_WIDTH:0];
      almost_full   <= cap_next >= THRESHOLD;
    end
  end
endmodule

// File: tb/tb_logic_basic_queue_generic_write.sv
// tb_logic_basic_queue_generic_write: directed fill/drain/reset plus random traffic
// against a word-count reference model with an accepted-data scoreboard.
module tb_logic_basic_queue_generic_write;
  localparam int DW = 8, AW = 2, AF = 1, DEPTH = 4;
  logic          aclk = 0, areset_n, rx_tvalid, rx_tready, write_enable, read_enable, almost_full;
  logic [DW-1:0] rx_tdata, write_data;
  logic [AW-1:0] write_pointer;
  logic [AW:0]   capacity;
  int vectors = 0, miscompares = 0;
  int m_stored, m_words_written;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_inflight_data, m_last_data;
  bit m_inflight, m_ready, m_af;

  logic_basic_queue_generic_write #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL(AF)) dut (
    .aclk(aclk), .areset_n(areset_n), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .rx_tdata(rx_tdata), .write_enable(write_enable), .write_pointer(write_pointer),
    .write_data(write_data), .read_enable(read_enable), .capacity(capacity),
    .almost_full(almost_full));

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit v, input logic [DW-1:0] d, input bit re);
    bit acc;
    int committed;
    areset_n = rst_n; rx_tvalid = v; rx_tdata = d; read_enable = re;
    @(posedge aclk);
    if (!rst_n) begin
      m_stored = 0; m_words_written = 0; m_inflight = 0; m_ready = 0; m_af = 0;
      m_last_data = '0; sb.delete();
    end else begin
      acc = v && m_ready;
      // the in-flight word is committed this edge; a read removes one committed word
      committed = m_stored + (m_inflight ? 1 : 0);
      m_words_written += m_inflight ? 1 : 0;
      m_stored = (re && committed > 0) ? committed - 1 : committed;
      m_inflight = acc;
      if (acc) begin
        m_inflight_data = d;
        m_last_data = d;
        sb.push_back(d);
      end
      m_ready = (m_stored + (acc ? 1 : 0)) < DEPTH;
      m_af = m_stored >= DEPTH - AF;
    end
    #1;
    check("rx_tready", int'(rx_tready), int'(m_ready));
    check("write_enable", int'(write_enable), int'(m_inflight));
    check("write_pointer", int'(write_pointer), m_words_written % DEPTH);
    check("write_data", int'(write_data), int'(m_last_data));
    check("capacity", int'(capacity), m_stored);
    check("almost_full", int'(almost_full), int'(m_af));
    if (write_enable === 1'b1 && m_inflight) begin
      check("sb_order", int'(write_data), int'(sb[0]));
      void'(sb.pop_front());
    end
  endtask

  initial begin
    m_stored = 0; m_words_written = 0; m_inflight = 0; m_ready = 0; m_af = 0;
    m_last_data = '0;
    areset_n = 0; rx_tvalid = 0; rx_tdata = '0; read_enable = 0;
    step(0, 1, 8'hAA, 0);
    step(0, 1, 8'hAB, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h10 + m_words_written + (m_inflight ? 1 : 0)), 0);
    check("full_capacity", int'(capacity), DEPTH);
    check("full_last_word", int'(write_data), 8'h13);
    step(1, 1, 8'h14, 1);
    check("after_read_cap", int'(capacity), DEPTH - 1);
    for (int i = 0; i < 4; i++) step(1, 1, 8'h14, 0);
    check("refill_cap", int'(capacity), DEPTH);
    check("refill_data", int'(write_data), 8'h14);
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00, 1);
    check("drain_empty_cap", int'(capacity), 0);
    step(1, 0, 8'h00, 1);
    check("underflow_cap", int'(capacity), 0);
    for (int i = 0; i < 600; i++) begin
      bit rst_n, v, re;
      rst_n = ($urandom_range(0, 49) != 0);
      v     = ($urandom_range(0, 9) < 7);
      re    = ($urandom_range(0, 9) < (i % 200 < 100 ? 2 : 6));
      step(rst_n, v, 8'($urandom), re);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
